// File: rtl/arith_pkg.sv
// Shared definitions for the adder/subtractor family: FSM state encoding and
// a ceiling-log2 helper used to size internal counters.
package arith_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit subtractor cells: a half subtractor, and a full subtractor built
// from two of them with the two partial borrows ORed together.
module half_subtractor (
   input  logic a,
   input  logic b,
   output logic diff,
   output logic bout
);
   assign diff = a ^ b;
   assign bout = ~a & b;
endmodule

module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic diff,
   output logic bout
);
   logic d1;
   logic b1;
   logic b2;

   half_subtractor u_hs0 (.a(a),  .b(b),   .diff(d1),   .bout(b1));
   half_subtractor u_hs1 (.a(d1), .b(bin), .diff(diff), .bout(b2));

   assign bout = b1 | b2;
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: DIFF = A - B - BIN, one bit per clock,
// LSB first, with a start/busy/done handshake.
module serial_subtractor
   import arith_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout
);
   localparam int CNT_W = clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t           state_q,   state_d;
   logic [WIDTH-1:0] a_sr_q,    a_sr_d;
   logic [WIDTH-1:0] b_sr_q,    b_sr_d;
   logic [WIDTH-1:0] diff_sr_q, diff_sr_d;
   logic [WIDTH-1:0] diff_q,    diff_d;
   logic [CNT_W-1:0] cnt_q,     cnt_d;
   logic             brw_q,     brw_d;
   logic             bout_q,    bout_d;
   logic             bit_diff;
   logic             bit_bout;

   full_subtractor u_fs (
      .a    (a_sr_q[0]),
      .b    (b_sr_q[0]),
      .bin  (brw_q),
      .diff (bit_diff),
      .bout (bit_bout)
   );

   always_comb begin
      state_d   = state_q;
      a_sr_d    = a_sr_q;
      b_sr_d    = b_sr_q;
      diff_sr_d = diff_sr_q;
      diff_d    = diff_q;
      cnt_d     = cnt_q;
      brw_d     = brw_q;
      bout_d    = bout_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               a_sr_d    = a;
               b_sr_d    = b;
               brw_d     = bin;
               cnt_d     = '0;
               diff_sr_d = '0;
               state_d   = ST_RUN;
            end
         end
         ST_RUN: begin
            a_sr_d    = {1'b0, a_sr_q[WIDTH-1:1]};
            b_sr_d    = {1'b0, b_sr_q[WIDTH-1:1]};
            diff_sr_d = {bit_diff, diff_sr_q[WIDTH-1:1]};
            brw_d     = bit_bout;
            cnt_d     = cnt_q + CNT_W'(1);
            // Publish the result on the last bit so diff/bout are valid with done.
            if (cnt_q == CNT_LAST) begin
               diff_d  = {bit_diff, diff_sr_q[WIDTH-1:1]};
               bout_d  = bit_bout;
               state_d = ST_DONE;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         a_sr_q    <= '0;
         b_sr_q    <= '0;
         diff_sr_q <= '0;
         diff_q    <= '0;
         cnt_q     <= '0;
         brw_q     <= 1'b0;
         bout_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_sr_q    <= a_sr_d;
         b_sr_q    <= b_sr_d;
         diff_sr_q <= diff_sr_d;
         diff_q    <= diff_d;
         cnt_q     <= cnt_d;
         brw_q     <= brw_d;
         bout_q    <= bout_d;
      end
   end

   assign busy = (state_q == ST_RUN);
   assign done = (state_q == ST_DONE);
   assign diff = diff_q;
   assign bout = bout_q;

endmodule
